// File: rtl/alu_regfile_unit.sv
// WIDTH-bit ALU with NREGS-entry register file, registered result/flags and a stored
// carry for multi-precision chains; valid/ready on both sides, one-cycle latency.
module alu_regfile_unit #(
  parameter int WIDTH = 8,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       I,
  input  logic             CI,
  input  logic [AW-1:0]    A_ADDR,
  input  logic [AW-1:0]    B_ADDR,
  input  logic             SRC_D,
  input  logic [WIDTH-1:0] D,
  input  logic             WE,
  input  logic [AW-1:0]    DEST,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             CO,
  output logic             VO,
  output logic             NO,
  output logic             ZO,
  output logic             CF
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] s_op;
  logic [WIDTH-1:0] f_next;
  logic [WIDTH:0]   wide;
  logic             co_next;
  logic             vo_next;
  logic             is_sub;
  logic             is_arith;
  logic             cin;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign r_op     = SRC_D ? D : regs[A_ADDR];
  assign s_op     = regs[B_ADDR];

  // Opcodes 11x take the stored carry instead of CI, hence the I[2] select.
  always_comb begin
    is_sub   = (I == 3'b000) || (I == 3'b111);
    is_arith = is_sub || (I == 3'b010) || (I == 3'b110);
    cin      = I[2] ? CF : CI;
    wide     = '0;
    f_next   = '0;
    co_next  = 1'b0;
    vo_next  = 1'b0;
    case (I)
      3'b000, 3'b111: wide = {1'b0, s_op} + {1'b0, ~r_op} + {{WIDTH{1'b0}}, cin};
      3'b010, 3'b110: wide = {1'b0, s_op} + {1'b0, r_op} + {{WIDTH{1'b0}}, cin};
      3'b001:         f_next = s_op | r_op;
      3'b011:         f_next = ~(s_op ^ r_op);
      3'b100:         f_next = s_op & r_op;
      3'b101:         f_next = s_op ^ r_op;
      default:        f_next = '0;
    endcase
    if (is_arith) begin
      f_next  = wide[WIDTH-1:0];
      co_next = wide[WIDTH];
      vo_next = (is_sub ? (s_op[WIDTH-1] != r_op[WIDTH-1])
                        : (s_op[WIDTH-1] == r_op[WIDTH-1]))
                && (f_next[WIDTH-1] != s_op[WIDTH-1]);
    end
  end

  // Operands were read before this edge, so a write to a source register is seen next op.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      F         <= '0;
      CO        <= 1'b0;
      VO        <= 1'b0;
      NO        <= 1'b0;
      ZO        <= 1'b0;
      CF        <= 1'b0;
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      F         <= f_next;
      CO        <= co_next;
      VO        <= vo_next;
      NO        <= f_next[WIDTH-1];
      ZO        <= (f_next == '0);
      if (is_arith) CF <= co_next;
      if (WE) regs[DEST] <= f_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_regfile_unit.sv
// Self-checking bench for alu_regfile_unit: directed spec scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_regfile_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op_i;
  logic       ci;
  logic [3:0] a_addr;
  logic [3:0] b_addr;
  logic       src_d;
  logic [7:0] d;
  logic       we;
  logic [3:0] dest;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] f;
  logic       co, vo, no, zo, cf;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_regs [16];
  logic        m_cf;
  logic [13:0] exp_vec;
  logic [13:0] obs;

  alu_regfile_unit #(.WIDTH(8), .NREGS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .I(op_i), .CI(ci), .A_ADDR(a_addr), .B_ADDR(b_addr), .SRC_D(src_d),
    .D(d), .WE(we), .DEST(dest), .out_valid(out_valid), .out_ready(out_ready),
    .F(f), .CO(co), .VO(vo), .NO(no), .ZO(zo), .CF(cf)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, f, co, vo, no, zo, cf};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: unsigned/signed integer arithmetic on the register model.
  task automatic model_step(input logic [2:0] op, input logic c_in, input logic sd,
                            input logic [7:0] dv, input logic [3:0] a, input logic [3:0] b,
                            input logic w, input logic [3:0] dst);
    logic [7:0] r, s, res;
    int su, ru, si, ri, c, t, sv;
    logic arith, c_out, v_out;
    r = sd ? dv : m_regs[a];
    s = m_regs[b];
    su = int'(s); ru = int'(r);
    si = (su > 127) ? su - 256 : su;
    ri = (ru > 127) ? ru - 256 : ru;
    c = ((op == 3'd6 || op == 3'd7) ? m_cf : c_in) ? 1 : 0;
    arith = 1'b0; c_out = 1'b0; v_out = 1'b0; res = '0; t = 0; sv = 0;
    case (op)
      3'd0, 3'd7: begin t = su - ru - 1 + c; sv = si - ri - 1 + c; arith = 1'b1; c_out = (t >= 0); end
      3'd2, 3'd6: begin t = su + ru + c; sv = si + ri + c; arith = 1'b1; c_out = (t > 255); end
      3'd1: res = s | r;
      3'd3: res = ~(s ^ r);
      3'd4: res = s & r;
      default: res = s ^ r;
    endcase
    if (arith) begin
      res = t[7:0];
      v_out = (sv > 127) || (sv < -128);
    end
    if (arith) m_cf = c_out;
    exp_vec = {1'b1, res, c_out, v_out, res[7], (res == 8'h00), m_cf};
    if (w) m_regs[dst] = res;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic c_in, input logic sd,
                          input logic [7:0] dv, input logic [3:0] a, input logic [3:0] b,
                          input logic w, input logic [3:0] dst);
    op_i = op; ci = c_in; src_d = sd; d = dv; a_addr = a; b_addr = b; we = w; dest = dst;
    in_valid = 1'b1;
    model_step(op, c_in, sd, dv, a, b, w, dst);
  endtask

  task automatic do_op(input logic [2:0] op, input logic c_in, input logic sd,
                       input logic [7:0] dv, input logic [3:0] a, input logic [3:0] b,
                       input logic w, input logic [3:0] dst);
    drive_op(op, c_in, sd, dv, a, b, w, dst);
    @(posedge clk); #1;
    in_valid = 1'b0;
    we = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_cf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    op_i = 3'd2; ci = 1'b0; src_d = 1'b1; d = 8'h42; a_addr = 0; b_addr = 0;
    we = 1'b1; dest = 4'd1; in_valid = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 14'h0) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 14'h0); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0; we = 1'b0;
    do_op(3'd1, 0, 1, 8'h00, 0, 1, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h00, 5'b00010}) begin errors++; $display("[TB] FAIL reset_drop_r1: got %h expected %h", obs, {1'b1, 8'h00, 5'b00010}); end
  endtask

  task automatic test_load();
    do_op(3'd2, 0, 1, 8'h7F, 0, 0, 1, 4'd1);
    checks++;
    if (obs !== {1'b1, 8'h7F, 5'b00000}) begin errors++; $display("[TB] FAIL load: got %h expected %h", obs, {1'b1, 8'h7F, 5'b00000}); end
    do_op(3'd1, 0, 1, 8'h00, 0, 4'd1, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h7F, 5'b00000}) begin errors++; $display("[TB] FAIL load_readback: got %h expected %h", obs, {1'b1, 8'h7F, 5'b00000}); end
  endtask

  task automatic test_overflow();
    do_op(3'd2, 0, 1, 8'h01, 0, 4'd1, 1, 4'd2);
    checks++;
    if (obs !== {1'b1, 8'h80, 5'b01100}) begin errors++; $display("[TB] FAIL add_overflow: got %h expected %h", obs, {1'b1, 8'h80, 5'b01100}); end
  endtask

  task automatic test_subtract();
    do_op(3'd0, 1, 1, 8'h01, 0, 4'd0, 1, 4'd3);
    checks++;
    if (obs !== {1'b1, 8'hFF, 5'b00100}) begin errors++; $display("[TB] FAIL sub_borrow: got %h expected %h", obs, {1'b1, 8'hFF, 5'b00100}); end
    do_op(3'd0, 1, 1, 8'h01, 0, 4'd2, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h7F, 5'b11001}) begin errors++; $display("[TB] FAIL sub_overflow: got %h expected %h", obs, {1'b1, 8'h7F, 5'b11001}); end
  endtask

  task automatic test_chain();
    do_op(3'd2, 0, 1, 8'h01, 0, 4'd3, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h00, 5'b10011}) begin errors++; $display("[TB] FAIL chain_add: got %h expected %h", obs, {1'b1, 8'h00, 5'b10011}); end
    do_op(3'd1, 0, 1, 8'h00, 0, 4'd0, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h00, 5'b00011}) begin errors++; $display("[TB] FAIL chain_or_keeps_cf: got %h expected %h", obs, {1'b1, 8'h00, 5'b00011}); end
    do_op(3'd6, 0, 1, 8'h00, 0, 4'd0, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h01, 5'b00000}) begin errors++; $display("[TB] FAIL chain_addc: got %h expected %h", obs, {1'b1, 8'h01, 5'b00000}); end
  endtask

  task automatic test_backpressure();
    do_op(3'd1, 0, 1, 8'h00, 0, 4'd1, 0, 0);
    out_ready = 1'b0;
    drive_op(3'd2, 0, 1, 8'h01, 0, 4'd4, 1, 4'd4);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_low: got %b expected 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== {1'b1, 8'h7F, 5'b00000}) begin errors++; $display("[TB] FAIL bp_hold_%0d: got %h expected %h", k, obs, {1'b1, 8'h7F, 5'b00000}); end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready_high: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; we = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h01, 5'b00000}) begin errors++; $display("[TB] FAIL bp_release: got %h expected %h", obs, {1'b1, 8'h01, 5'b00000}); end
    do_op(3'd1, 0, 1, 8'h00, 0, 4'd4, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h01, 5'b00000}) begin errors++; $display("[TB] FAIL bp_single_write: got %h expected %h", obs, {1'b1, 8'h01, 5'b00000}); end
  endtask

  task automatic test_reset_mid();
    do_op(3'd2, 0, 1, 8'h90, 0, 4'd0, 0, 0);
    out_ready = 1'b0;
    op_i = 3'd2; ci = 1'b0; src_d = 1'b1; d = 8'h33; a_addr = 0; b_addr = 0;
    we = 1'b1; dest = 4'd2; in_valid = 1'b1; rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (obs !== 14'h0) begin errors++; $display("[TB] FAIL reset_mid: got %h expected %h", obs, 14'h0); end
    rst = 1'b0; in_valid = 1'b0; we = 1'b0; out_ready = 1'b1;
    do_op(3'd2, 0, 1, 8'h7F, 0, 0, 1, 4'd1);
    checks++;
    if (obs !== {1'b1, 8'h7F, 5'b00000}) begin errors++; $display("[TB] FAIL reset_mid_load: got %h expected %h", obs, {1'b1, 8'h7F, 5'b00000}); end
    do_op(3'd1, 0, 1, 8'h00, 0, 4'd2, 0, 0);
    checks++;
    if (obs !== {1'b1, 8'h00, 5'b00010}) begin errors++; $display("[TB] FAIL reset_mid_r2: got %h expected %h", obs, {1'b1, 8'h00, 5'b00010}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      checks++;
      if (obs !== exp_vec) begin errors++; $display("[TB] FAIL random_%0d op=%0d: got %h expected %h", n, op_i, obs, exp_vec); end
    end
  endtask

  initial begin
    in_valid = 1'b0; we = 1'b0; out_ready = 1'b1; rst = 1'b1;
    op_i = '0; ci = 1'b0; src_d = 1'b0; d = '0; a_addr = '0; b_addr = '0; dest = '0;
    #1;
    test_reset();
    test_load();
    test_overflow();
    test_subtract();
    test_chain();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
